// File: rtl/fd_pipe_reg.sv
// Fetch-to-Decode pipeline register: captures F PC/instruction, flags AdEL, tags delay slot.
// Optional performance counters are built when FD_PERF_CNT_EN is defined.
module fd_pipe_reg #(
  parameter logic [31:0] PC_BASE   = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT  = 32'h0000_6FFC,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        d_is_bj,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exc_code,
  output logic        d_bd,
  output logic        d_valid,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_bubbles
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [4:0]  r_exc_code;
  logic        r_bd;
  logic        r_valid;
  logic        w_adel;

  // Unsigned 32-bit range check; no wrap handling at the top of the address space.
  assign w_adel = (f_pc[1:0] != 2'b00) || (f_pc < PC_BASE) || (f_pc > PC_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= PC_BASE;
      r_instr    <= 32'h0;
      r_exc_code <= 5'd0;
      r_bd       <= 1'b0;
      r_valid    <= 1'b0;
    end else if (req) begin
      r_pc       <= EXC_ENTRY;
      r_instr    <= 32'h0;
      r_exc_code <= 5'd0;
      r_bd       <= 1'b0;
      r_valid    <= 1'b0;
    end else if (stall) begin
      // Hold: the stalling D instruction must survive even if flush is also raised.
      r_pc       <= r_pc;
      r_instr    <= r_instr;
      r_exc_code <= r_exc_code;
      r_bd       <= r_bd;
      r_valid    <= r_valid;
    end else if (flush) begin
      r_pc       <= f_pc;
      r_instr    <= 32'h0;
      r_exc_code <= 5'd0;
      r_bd       <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      // d_bd is kept on AdEL so CP0 can form EPC = d_pc - 4.
      r_pc       <= f_pc;
      r_instr    <= w_adel ? 32'h0 : f_instr;
      r_exc_code <= w_adel ? EXC_ADEL : 5'd0;
      r_bd       <= d_is_bj;
      r_valid    <= 1'b1;
    end
  end

  assign d_pc       = r_pc;
  assign d_instr    = r_instr;
  assign d_exc_code = r_exc_code;
  assign d_bd       = r_bd;
  assign d_valid    = r_valid;

`ifdef FD_PERF_CNT_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_bubbles;

  // Counters survive req; only reset clears them. Both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issued  <= 32'h0;
      r_perf_bubbles <= 32'h0;
    end else if (req) begin
      r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end else if (stall) begin
      r_perf_issued  <= r_perf_issued;
      r_perf_bubbles <= r_perf_bubbles;
    end else if (flush) begin
      r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end else begin
      r_perf_issued  <= r_perf_issued + 32'd1;
    end
  end

  assign perf_issued  = r_perf_issued;
  assign perf_bubbles = r_perf_bubbles;
`else
  assign perf_issued  = 32'h0;
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Self-checking bench for fd_pipe_reg: driver pushes expected D-stage state per edge,
// monitor pops and compares one cycle later.
module tb_fd_pipe_reg;

  localparam logic [31:0] PC_BASE   = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT  = 32'h0000_6FFC;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam int W = 135;
`ifdef FD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, req = 1'b0, stall = 1'b0, flush = 1'b0, d_is_bj = 1'b0;
  logic [31:0] f_pc = 32'h0, f_instr = 32'h0;
  logic [31:0] d_pc, d_instr, perf_issued, perf_bubbles;
  logic [4:0]  d_exc_code;
  logic        d_bd, d_valid;

  fd_pipe_reg dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .f_pc(f_pc), .f_instr(f_instr), .d_is_bj(d_is_bj),
    .d_pc(d_pc), .d_instr(d_instr), .d_exc_code(d_exc_code), .d_bd(d_bd),
    .d_valid(d_valid), .perf_issued(perf_issued), .perf_bubbles(perf_bubbles)
  );

  // ---------------- reference model ----------------
  // Expected D contents tracked as plain variables, updated from the behavioural rules.
  longint unsigned m_pc = 0, m_instr = 0;
  int unsigned     m_exc = 0;
  bit              m_bd = 0, m_valid = 0;
  longint unsigned m_iss = 0, m_bub = 0;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic bit is_adel(longint unsigned pc);
    return (pc % 4 != 0) || (pc < PC_BASE) || (pc > PC_LIMIT);
  endfunction

  task automatic model_edge();
    logic [31:0] pi, pb;
    if (reset) begin
      m_pc = PC_BASE; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_iss = 0; m_bub = 0;
    end else if (req) begin
      m_pc = EXC_ENTRY; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_bub = (m_bub + 1) % 64'h1_0000_0000;
    end else if (stall) begin
      // nothing changes
    end else if (flush) begin
      m_pc = f_pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      m_bub = (m_bub + 1) % 64'h1_0000_0000;
    end else begin
      m_pc = f_pc; m_valid = 1; m_bd = d_is_bj;
      if (is_adel(f_pc)) begin m_instr = 0; m_exc = 4; end
      else begin m_instr = f_instr; m_exc = 0; end
      m_iss = (m_iss + 1) % 64'h1_0000_0000;
    end
    pi = PERF_EN ? 32'(m_iss) : 32'h0;
    pb = PERF_EN ? 32'(m_bub) : 32'h0;
    exp_q.push_back({32'(m_pc), 32'(m_instr), 5'(m_exc), m_bd, m_valid, pi, pb});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit q, input bit s, input bit f,
                       input logic [31:0] pc, input logic [31:0] ins, input bit bj);
    @(negedge clk);
    reset = r; req = q; stall = s; flush = f; f_pc = pc; f_instr = ins; d_is_bj = bj;
    model_edge();
  endtask

  task automatic normal(input logic [31:0] pc, input logic [31:0] ins, input bit bj);
    drive(0, 0, 0, 0, pc, ins, bj);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("d_pc",         d_pc,                e[134:103]);
        check("d_instr",      d_instr,             e[102:71]);
        check("d_exc_code",   {27'h0, d_exc_code}, {27'h0, e[70:66]});
        check("d_bd",         {31'h0, d_bd},       {31'h0, e[65]});
        check("d_valid",      {31'h0, d_valid},    {31'h0, e[64]});
        check("perf_issued",  perf_issued,         e[63:32]);
        check("perf_bubbles", perf_bubbles,        e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_pc();
    logic [31:0] edges [8];
    edges[0] = PC_BASE;          edges[1] = PC_BASE - 32'd4;
    edges[2] = PC_LIMIT;         edges[3] = PC_LIMIT + 32'd4;
    edges[4] = 32'hFFFF_FFFC;    edges[5] = 32'hFFFF_FFFF;
    edges[6] = 32'h0;            edges[7] = PC_BASE + 32'd2;
    case ($urandom_range(0, 5))
      0, 1, 2: return PC_BASE + 32'($urandom_range(0, 32'h0FFF)) * 32'd4;
      3:       return edges[$urandom_range(0, 7)];
      4:       return $urandom;
      default: return PC_BASE + 32'($urandom_range(0, 32'h0FFF)) * 32'd4
                      + 32'($urandom_range(1, 3));
    endcase
  endfunction

  initial begin : stimulus
    int wait_cyc;
    // Reset then normal fetch
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    normal(32'h3000, 32'h3C01_1234, 0);
    normal(32'h3004, 32'h2402_0005, 0);
    normal(32'h3008, 32'h0043_1820, 0);
    // stall + flush for 2 cycles: D must keep 3008
    drive(0, 0, 1, 1, 32'h300C, 32'h1111_1111, 0);
    drive(0, 0, 1, 1, 32'h300C, 32'h1111_1111, 0);
    normal(32'h300C, 32'h1111_1111, 0);
    // AdEL cases and the legal upper bound
    normal(32'h3002, 32'hAAAA_AAAA, 0);
    normal(32'h2FFC, 32'hBBBB_BBBB, 0);
    normal(32'h7000, 32'hCCCC_CCCC, 0);
    normal(32'h6FFC, 32'hDDDD_DDDD, 0);
    normal(32'hFFFF_FFFC, 32'hEEEE_EEEE, 0);
    // Delay slot with AdEL
    normal(32'h3001, 32'h1234_5678, 1);
    // req over stall with D holding 3010
    normal(32'h3010, 32'h0000_0020, 0);
    drive(0, 1, 1, 0, 32'h3014, 32'h5555_5555, 0);
    // flush alone, then reset together with req
    normal(32'h3018, 32'h6666_6666, 1);
    drive(0, 0, 0, 1, 32'h301C, 32'h7777_7777, 0);
    drive(1, 1, 1, 0, 32'h3020, 32'h8888_8888, 0);
    // Perf scenario: 3 normal, 1 flush, 2 stalls, 1 req
    normal(32'h3000, 32'h1, 0);
    normal(32'h3004, 32'h2, 0);
    normal(32'h3008, 32'h3, 0);
    drive(0, 0, 0, 1, 32'h300C, 32'h4, 0);
    drive(0, 0, 1, 0, 32'h3010, 32'h5, 0);
    drive(0, 0, 1, 0, 32'h3010, 32'h5, 0);
    drive(0, 1, 0, 0, 32'h3014, 32'h6, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
            rand_pc(), $urandom, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    reset = 1'b0; req = 1'b0; stall = 1'b1; flush = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
